riscv_boot_ctrl: RTL and testbench
==================================

// Module: riscv_boot_ctrl
// PURPOSE
//  Boot/run sequencer for RISCV_Processor_pipelined. Streams a program byte-wise into
//  instruction memory, holds the core in reset while loading, then releases it.
//  Runs the core until it signals halt or a cycle budget expires, then freezes it
//  with architectural state intact for inspection.
// PARAMETERS
//  IMEM_DEPTH  256  instruction memory depth in 32-bit words
//  ADDR_W      8    imem word-address width (clog2 IMEM_DEPTH)
//  RST_CYCLES  2    cycles core_rst held high before run
//  MAX_CYCLES  200  run budget in clock cycles
//  CNT_W       16   width of run_cycles counter
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       pulse: begin a load (honoured only in IDLE or DONE)
//  ld_data     in   8       program byte, little-endian within each word
//  ld_valid    in   1       ld_data valid
//  ld_last     in   1       qualifies final byte of program (with ld_valid)
//  ld_ready    out  1       controller accepts byte; transfer = ld_valid & ld_ready
//  imem_we     out  1       imem write strobe, one cycle per word
//  imem_addr   out  ADDR_W  imem word address
//  imem_wdata  out  32      imem write data
//  core_rst    out  1       reset to core
//  core_stall  out  1       freezes core pipeline (PC and all stage registers hold)
//  core_halt   in   1       core retired halt instruction (ecall)
//  run_cycles  out  CNT_W   cycles spent in RUN
//  busy / done / timeout / err  out 1 each  status flags
// BEHAVIOUR
//  Reset values: ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1,
//   core_stall=1, run_cycles=0, busy=0, done=0, timeout=0, err=0; state=IDLE.
//  States: IDLE -> LOAD -> CORE_RST -> RUN -> DONE.
//  IDLE: core_rst=1, core_stall=1. start -> LOAD; clears run_cycles/done/timeout/err,
//   byte index, word address.
//  LOAD: ld_ready=1, busy=1, core_rst=1. Byte k of word lands in bits [8k+7:8k].
//   On 4th byte transfer, imem_we=1 exactly one cycle later with assembled word at
//   current address. Address increments after each write; no gaps needed between bytes.
//   ld_last on 4th byte: final write issued, then -> CORE_RST.
//   ld_last on byte 1-3: err=1, partial word discarded, no write, -> DONE (core kept in reset).
//   Transfer when IMEM_DEPTH words already written: err=1, byte dropped, -> DONE.
//   ld_valid low: hold; no timeout on load.
//  CORE_RST: ld_ready=0, core_rst=1 for exactly RST_CYCLES cycles, then -> RUN.
//  RUN: core_rst=0, core_stall=0, busy=1; run_cycles +1 per cycle (saturates).
//   core_halt -> DONE. run_cycles==MAX_CYCLES-1 with no halt -> DONE, timeout=1.
//   Halt and budget in same cycle: halt wins, timeout=0.
//  DONE: done=1, busy=0, core_stall=1, core_rst=0 (register file/dmem preserved).
//   start -> LOAD (reload, flags cleared). start ignored in LOAD/CORE_RST/RUN.
//  rst mid-operation: all outputs to reset values next edge; partial word dropped;
//   imem contents not altered.
//  Outputs registered; no combinational path from inputs to outputs except none.
// TESTING
//  1. start, 8 bytes 13 05 00 00 93 05 10 00, last on 8th -> writes addr0=00000513,
//     addr1=00100593; 2 cycles core_rst; RUN.
//  2. Program ending in ecall, core_halt at RUN cycle 37 -> done=1, timeout=0,
//     run_cycles=38, core_stall=1.
//  3. core_halt never -> DONE after 200 RUN cycles, timeout=1, run_cycles=200.
//  4. 6 bytes with ld_last on 6th -> one write only (addr0), err=1, core_rst stays 1.
//  5. ld_valid toggled 1/0 every cycle over 4 bytes -> single correct write, no dup.
//  6. rst asserted after 2nd byte -> all outputs reset values, no imem_we; new start
//     reloads from addr 0.

Source files
------------

// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: streams a byte-wise program into imem, holds the core in reset,
// runs it until halt or cycle budget, then freezes it for inspection.
//   state      | meaning
//   S_IDLE     | waiting for start, core held in reset
//   S_LOAD     | accepting program bytes, writing assembled words
//   S_CORE_RST | program loaded, core reset held for RST_CYCLES
//   S_RUN      | core running, counting cycles
//   S_DONE     | core frozen (or held in reset after a load error)
module riscv_boot_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 200,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              core_stall,
  input  logic              core_halt,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err
);

  localparam int RW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WCW = $clog2(IMEM_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CORE_RST, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              core_stall_q, core_stall_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic              xfer;

  assign xfer = ld_valid & ld_ready_q;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    wcnt_d       = wcnt_q;
    rst_cnt_d    = rst_cnt_q;
    ld_ready_d   = ld_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_d   = core_rst_q;
    core_stall_d = core_stall_q;
    run_cycles_d = run_cycles_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    err_d        = err_q;

    if (imem_we_q) imem_addr_d = imem_addr_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          ld_ready_d   = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          err_d        = 1'b0;
          run_cycles_d = '0;
          byte_idx_d   = '0;
          wcnt_d       = '0;
          imem_addr_d  = '0;
          core_rst_d   = 1'b1;
          core_stall_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          // Overflow and short final words abort to DONE with the core left in reset.
          if (wcnt_q == WCW'(IMEM_DEPTH) || (ld_last && byte_idx_q != 2'd3)) begin
            state_d    = S_DONE;
            err_d      = 1'b1;
            ld_ready_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {ld_data, word_q};
            wcnt_d       = wcnt_q + 1'b1;
            byte_idx_d   = '0;
            if (ld_last) begin
              state_d    = S_CORE_RST;
              ld_ready_d = 1'b0;
              rst_cnt_d  = RW'(RST_CYCLES - 1);
            end
          end else begin
            case (byte_idx_q)
              2'd0:    word_d[7:0]   = ld_data;
              2'd1:    word_d[15:8]  = ld_data;
              default: word_d[23:16] = ld_data;
            endcase
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_CORE_RST: begin
        if (rst_cnt_q == '0) begin
          state_d      = S_RUN;
          core_rst_d   = 1'b0;
          core_stall_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
        if (core_halt || run_cycles_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d      = S_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          core_stall_d = 1'b1;
          timeout_d    = ~core_halt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      word_q       <= '0;
      wcnt_q       <= '0;
      rst_cnt_q    <= '0;
      ld_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      core_stall_q <= 1'b1;
      run_cycles_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      wcnt_q       <= wcnt_d;
      rst_cnt_q    <= rst_cnt_d;
      ld_ready_q   <= ld_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      core_stall_q <= core_stall_d;
      run_cycles_q <= run_cycles_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  assign ld_ready   = ld_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign core_stall = core_stall_q;
  assign run_cycles = run_cycles_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Bench for riscv_boot_ctrl: directed load/run sequences; expected imem writes and
// completion status are queued by the stimulus and checked by an independent monitor.
module tb_riscv_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ld_valid, ld_last, core_halt;
  logic [7:0]  ld_data;
  logic        ld_ready, imem_we, core_rst, core_stall, busy, done, timeout, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] run_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  typedef struct packed {logic timeout; logic err; logic core_rst; logic core_stall; logic [15:0] rc;} dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  riscv_boot_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .core_stall(core_stall),
    .core_halt(core_halt), .run_cycles(run_cycles), .busy(busy), .done(done),
    .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_core_stall"}, core_stall, 1);
    check({tag, "_run_cycles"}, run_cycles, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_data  = d;
    ld_valid = 1'b1;
    ld_last  = last;
    for (int t = 0; t < 50; t++) begin
      if (ld_ready) begin
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ld_ready_wait: got ld_ready=0 for 50 cycles, expected 1 (byte %h)", d);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (core_rst && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", core_rst, 0);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  // Monitor: compares every imem write and every done rising edge against the queues.
  initial begin
    logic done_prev;
    wr_t  w;
    dn_t  e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h data %h, expected no write", imem_addr, imem_wdata);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", imem_addr, w.addr);
          check("wr_data", imem_wdata, w.data);
        end
      end
      if (done === 1'b1 && !done_prev) begin
        if (exp_dn.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = exp_dn.pop_front();
          check("dn_timeout", timeout, e.timeout);
          check("dn_err", err, e.err);
          check("dn_core_rst", core_rst, e.core_rst);
          check("dn_core_stall", core_stall, e.core_stall);
          check("dn_run_cycles", run_cycles, e.rc);
          check("dn_busy", busy, 0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00; core_halt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("idle_core_rst", core_rst, 1);

    // Two-word program, then halt at RUN cycle 37.
    exp_wr.push_back('{8'd0, 32'h0000_0513});
    exp_wr.push_back('{8'd1, 32'h0010_0593});
    exp_dn.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'd38});
    do_start();
    check("load_busy", busy, 1);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 1);
    check("post_last_ld_ready", ld_ready, 0);
    wait_run(n);
    check("core_rst_cycles", n, 2);
    check("run_stall", core_stall, 0);
    check("run_busy", busy, 1);
    repeat (37) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    wait_done(5);

    // Budget expiry; a start pulse during RUN must be ignored.
    exp_wr.push_back('{8'd0, 32'h0000_006f});
    exp_dn.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'd200});
    do_start();
    send_byte(8'h6f, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 1);
    wait_run(n);
    repeat (10) @(negedge clk);
    do_start();
    wait_done(300);

    // ld_last on 2nd byte of second word: error, one write only, core stays in reset.
    exp_wr.push_back('{8'd0, 32'h0403_0201});
    exp_dn.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'd0});
    do_start();
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 1);
    wait_done(10);
    repeat (5) @(negedge clk);
    check("err_core_rst_held", core_rst, 1);
    check("err_ld_ready", ld_ready, 0);

    // ld_valid toggling, start pulse in LOAD ignored, halt on first RUN cycle.
    exp_wr.push_back('{8'd0, 32'hdead_beef});
    exp_dn.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'd1});
    do_start();
    send_byte(8'hef, 0); @(negedge clk);
    send_byte(8'hbe, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_byte(8'had, 0); @(negedge clk);
    send_byte(8'hde, 1);
    wait_run(n);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    wait_done(5);

    // Reset after 2nd byte; reload from address 0; halt coincides with budget.
    do_start();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    exp_wr.push_back('{8'd0, 32'h4433_2211});
    exp_dn.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'd200});
    do_start();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
    wait_run(n);
    repeat (199) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    wait_done(5);

    repeat (3) @(negedge clk);
    check("wr_queue_left", exp_wr.size(), 0);
    check("dn_queue_left", exp_dn.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
